// File: rtl/mc_dispatch.sv
// Multi-cycle dispatcher: issues one request at a time to NUM_UNITS functional units and returns a one-cycle writeback with result and ZCNV.
// Optional watchdog abort is compiled in with `define DISPATCH_TIMEOUT_EN.
module mc_dispatch #(
    parameter int NUM_UNITS      = 2,
    parameter int WIDTH          = 16,
    parameter int UIDX_W         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clock,
    input  logic                       reset_L,
    input  logic                       req_valid,
    input  logic [UIDX_W-1:0]          req_unit,
    output logic                       req_ready,
    output logic                       illegal_op,
    output logic [NUM_UNITS-1:0]       unit_start,
    output logic [NUM_UNITS-1:0]       unit_abort,
    input  logic [NUM_UNITS-1:0]       unit_done,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
    input  logic [NUM_UNITS*4-1:0]     unit_cc,
    output logic                       wb_valid,
    output logic [WIDTH-1:0]           wb_data,
    output logic [3:0]                 wb_cc,
    output logic                       busy,
    output logic                       timeout_err
);

    // Handshake: a request is taken when req_valid && req_ready at a rising edge;
    // req_valid seen while req_ready is low is dropped, so the requester must hold it.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t              state_q, state_d;
    logic [UIDX_W-1:0]   sel_q, sel_d;
    logic                illegal_q, illegal_d;
    logic [WIDTH-1:0]    wb_data_q, wb_data_d;
    logic [3:0]          wb_cc_q, wb_cc_d;

    logic                req_legal;
    logic                done_sel;
    logic [WIDTH-1:0]    res_sel;
    logic [3:0]          cc_sel;
    logic [NUM_UNITS-1:0] sel_onehot;
    logic                expire;

    assign req_legal = (32'(req_unit) < NUM_UNITS);

    // Everything below depends only on the latched index, never on req_unit.
    always_comb begin
        done_sel   = 1'b0;
        res_sel    = '0;
        cc_sel     = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (sel_q == UIDX_W'(i)) begin
                done_sel      = unit_done[i];
                res_sel       = unit_result[i*WIDTH +: WIDTH];
                cc_sel        = unit_cc[i*4 +: 4];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        illegal_d = 1'b0;
        wb_data_d = wb_data_q;
        wb_cc_d   = wb_cc_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        sel_d   = req_unit;
                        state_d = ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A done in the final watchdog cycle takes priority over the abort.
                if (done_sel) begin
                    wb_data_d = res_sel;
                    wb_cc_d   = cc_sel;
                    state_d   = WB;
                end else if (expire) begin
                    wb_data_d = '0;
                    wb_cc_d   = 4'b1000;
                    state_d   = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            illegal_q <= 1'b0;
            wb_data_q <= '0;
            wb_cc_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            illegal_q <= illegal_d;
            wb_data_q <= wb_data_d;
            wb_cc_q   <= wb_cc_d;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        terr_q, terr_d;

    assign expire = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        terr_d  = terr_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 16'd1;
            if (!done_sel && expire) begin
                abort_d = 1'b1;
                terr_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            terr_q  <= terr_d;
        end
    end

    assign unit_abort  = abort_q ? sel_onehot : '0;
    assign timeout_err = terr_q;
`else
    assign expire      = 1'b0;
    assign unit_abort  = '0;
    assign timeout_err = 1'b0;
`endif

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign unit_start = (state_q == ISSUE) ? sel_onehot : '0;
    assign wb_valid   = (state_q == WB);
    assign wb_data    = wb_data_q;
    assign wb_cc      = wb_cc_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mc_dispatch.sv
// Directed bench for mc_dispatch (3 units, watchdog of 8 cycles when DISPATCH_TIMEOUT_EN is defined).
module tb_mc_dispatch;

    localparam int NU = 3;
    localparam int W  = 16;
    localparam int TO = 8;
`ifdef DISPATCH_TIMEOUT_EN
    localparam int LONG_LAT = 7;
    localparam int MIDWAIT  = 3;
`else
    localparam int LONG_LAT = 17;
    localparam int MIDWAIT  = 12;
`endif

    logic            clock = 1'b0;
    logic            reset_L;
    logic            req_valid;
    logic [1:0]      req_unit;
    logic            req_ready;
    logic            illegal_op;
    logic [NU-1:0]   unit_start;
    logic [NU-1:0]   unit_abort;
    logic [NU-1:0]   unit_done;
    logic [NU*W-1:0] unit_result;
    logic [NU*4-1:0] unit_cc;
    logic            wb_valid;
    logic [W-1:0]    wb_data;
    logic [3:0]      wb_cc;
    logic            busy;
    logic            timeout_err;

    mc_dispatch #(.NUM_UNITS(NU), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_L(reset_L), .req_valid(req_valid), .req_unit(req_unit),
        .req_ready(req_ready), .illegal_op(illegal_op), .unit_start(unit_start),
        .unit_abort(unit_abort), .unit_done(unit_done), .unit_result(unit_result),
        .unit_cc(unit_cc), .wb_valid(wb_valid), .wb_data(wb_data), .wb_cc(wb_cc),
        .busy(busy), .timeout_err(timeout_err)
    );

    // clock / cycle stamp
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc++;

    int errors = 0;
    int checks = 0;

    logic [19:0] exp_q[$];
    int wb_count = 0;
    int start_count = 0;
    int wb_cyc_last = 0;
    int wb_cyc_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // scoreboard: every wb_valid pops one expected {data, cc}
    always @(negedge clock) begin
        if (unit_start != '0) start_count++;
        if (wb_valid === 1'b1) begin
            wb_count++;
            wb_cyc_prev = wb_cyc_last;
            wb_cyc_last = cyc;
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                chk("wb_data", 32'(wb_data), 32'(e[19:4]));
                chk("wb_cc", 32'(wb_cc), 32'(e[3:0]));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_start"}, 32'(unit_start), 32'd0);
        chk({tag, "_abort"}, 32'(unit_abort), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_op), 32'd0);
        chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
        chk({tag, "_wb_data"}, 32'(wb_data), 32'd0);
        chk({tag, "_wb_cc"}, 32'(wb_cc), 32'd0);
    endtask

    // Issue one op to unit u whose done arrives lat cycles after its start;
    // optionally pulse a spurious done on unit spur_u in cycle spur_cyc (0 = none).
    task automatic do_op(input int u, input int lat, input logic [15:0] d, input logic [3:0] c,
                         input int spur_cyc, input int spur_u);
        unit_result[u*W +: W] = d;
        unit_cc[u*4 +: 4]     = c;
        req_unit  = 2'(u);
        req_valid = 1'b1;
        exp_q.push_back({d, c});
        step();
        chk("start_onehot", 32'(unit_start), 32'(1 << u));
        chk("ready_issue", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        if (spur_cyc == 1) unit_done[spur_u] = 1'b1;
        for (int k = 2; k <= lat + 1; k++) begin
            step();
            unit_done = '0;
            chk("wait_no_wb", 32'(wb_valid), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            if (k == 2) chk("start_single", 32'(unit_start), 32'd0);
            if (k == lat + 1) unit_done[u] = 1'b1;
            if (k == spur_cyc) unit_done[spur_u] = 1'b1;
        end
        step();
        unit_done = '0;
        chk("wb_strobe", 32'(wb_valid), 32'd1);
        chk("wb_no_abort", 32'(unit_abort), 32'd0);
        step();
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("wb_single", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        int s0;
        int w0;
        reset_L     = 1'b0;
        req_valid   = 1'b0;
        req_unit    = '0;
        unit_done   = '0;
        unit_result = {16'hC3C3, 16'hB2B2, 16'hA1A1};
        unit_cc     = 12'hF7E;
        step();
        step();
        reset_L = 1'b1;
        step();
        chk_reset_state("por");

        // unit 0, latency 1
        do_op(0, 1, 16'h0012, 4'b0000, 0, 0);

        // unit 1, long latency, spurious done from unit 0 in cycle 5
        unit_result[0 +: W] = 16'h5A5A;
        do_op(1, LONG_LAT, 16'hFFFE, 4'b0010, 5, 0);

        // unit 2, done pulsed during ISSUE must be ignored
        do_op(2, 3, 16'h8001, 4'b1001, 1, 2);

        // done in the last watchdog cycle still captures normally
        do_op(1, TO, 16'h0F0F, 4'b0101, 0, 0);

        // illegal index
        req_unit  = 2'd3;
        req_valid = 1'b1;
        step();
        chk("illegal_pulse", 32'(illegal_op), 32'd1);
        chk("illegal_no_start", 32'(unit_start), 32'd0);
        chk("illegal_ready", 32'(req_ready), 32'd1);
        chk("illegal_busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
        step();
        chk("illegal_clear", 32'(illegal_op), 32'd0);
        chk("illegal_no_start2", 32'(unit_start), 32'd0);
        chk("illegal_idle", 32'(req_ready), 32'd1);

        // back-to-back with req_valid held: unit 0 then unit 1, latency 2 each
        s0 = start_count;
        w0 = wb_count;
        unit_result[0 +: W] = 16'h1111;
        unit_cc[0 +: 4]     = 4'b0100;
        unit_result[W +: W] = 16'h2222;
        unit_cc[4 +: 4]     = 4'b0001;
        exp_q.push_back({16'h1111, 4'b0100});
        exp_q.push_back({16'h2222, 4'b0001});
        req_unit  = 2'd0;
        req_valid = 1'b1;
        step();
        chk("b2b_start0", 32'(unit_start), 32'b001);
        req_unit = 2'd1;
        step();
        step();
        unit_done[0] = 1'b1;
        step();
        unit_done = '0;
        chk("b2b_wb0", 32'(wb_valid), 32'd1);
        step();
        chk("b2b_idle", 32'(req_ready), 32'd1);
        step();
        chk("b2b_start1", 32'(unit_start), 32'b010);
        req_valid = 1'b0;
        step();
        step();
        unit_done[1] = 1'b1;
        step();
        unit_done = '0;
        chk("b2b_wb1", 32'(wb_valid), 32'd1);
        step();
        chk("b2b_ready", 32'(req_ready), 32'd1);
        chk("b2b_starts", 32'(start_count - s0), 32'd2);
        chk("b2b_wbs", 32'(wb_count - w0), 32'd2);
        chk("b2b_gap", 32'(wb_cyc_last - wb_cyc_prev), 32'd5);
        chk("wb_data_hold", 32'(wb_data), 32'h2222);
        step();
        chk("wb_cc_hold", 32'(wb_cc), 32'b0001);

`ifdef DISPATCH_TIMEOUT_EN
        // watchdog: unit 0 never completes
        unit_result[0 +: W] = 16'hBEEF;
        unit_cc[0 +: 4]     = 4'b0111;
        exp_q.push_back({16'h0000, 4'b1000});
        req_unit  = 2'd0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 2; k <= TO + 1; k++) begin
            step();
            chk("wd_wait_no_wb", 32'(wb_valid), 32'd0);
            chk("wd_wait_no_abort", 32'(unit_abort), 32'd0);
        end
        step();
        chk("wd_wb", 32'(wb_valid), 32'd1);
        chk("wd_abort", 32'(unit_abort), 32'b001);
        chk("wd_terr", 32'(timeout_err), 32'd1);
        step();
        chk("wd_abort_single", 32'(unit_abort), 32'd0);
        chk("wd_ready", 32'(req_ready), 32'd1);
        do_op(2, 2, 16'h7777, 4'b0011, 0, 0);
        chk("wd_terr_sticky", 32'(timeout_err), 32'd1);
`endif

        // reset in the middle of WAIT (unit 1 never completes)
        req_unit  = 2'd1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (MIDWAIT) step();
        chk("midwait_busy", 32'(busy), 32'd1);
        chk("midwait_no_wb", 32'(wb_valid), 32'd0);
        chk("midwait_no_abort", 32'(unit_abort), 32'd0);
        reset_L = 1'b0;
        step();
        step();
        reset_L = 1'b1;
        step();
        chk_reset_state("midwait_rst");

        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/mc_dispatch.md
# mc_dispatch

Parametrised multi-cycle execution dispatcher for the RISC240 control path. It generalises the single-multiplier start/done wait into a handshake with NUM_UNITS functional units (multiplier, divider, future coprocessors). The controlpath FSM hands it one request at a time; the block returns a single-cycle writeback strobe with result and ZCNV condition codes. It sits between controlpath and the datapath's multi-cycle units.

## Interface
- NUM_UNITS, 2: number of attached multi-cycle units (1..8)
- WIDTH, 16: result width
- UIDX_W, $clog2(NUM_UNITS) (min 1): unit index width
- TIMEOUT_CYCLES, 64: WAIT cycles before a watchdog abort (>=2; used only with DISPATCH_TIMEOUT_EN)

Ports:
- clock  in  1  rising-edge clock
- reset_L  in  1  one clock; reset is synchronous and active-low
- req_valid  in  1  controlpath requests a multi-cycle op
- req_unit  in  UIDX_W  target unit index
- req_ready  out  1  high only in IDLE
- illegal_op  out  1  one-cycle pulse: request with req_unit >= NUM_UNITS rejected
- unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse
- unit_abort  out  NUM_UNITS  one-hot, one-cycle abort pulse (watchdog only)
- unit_done  in  NUM_UNITS  per-unit completion strobe
- unit_result  in  NUM_UNITS*WIDTH  packed results, unit i at [i*WIDTH +: WIDTH]
- unit_cc  in  NUM_UNITS*4  packed ZCNV, unit i at [i*4 +: 4]
- wb_valid  out  1  one-cycle strobe: controlpath asserts DEST_REG and LOAD_CC
- wb_data  out  WIDTH  captured result, valid with wb_valid
- wb_cc  out  4  captured ZCNV, valid with wb_valid
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: req_ready=1. req_valid with legal req_unit -> latch index sel, go ISSUE. Illegal index -> illegal_op=1 next cycle, stay IDLE, no unit_start.
- ISSUE: unit_start[sel]=1 for exactly this cycle; clear watchdog counter; go WAIT.
- WAIT: on unit_done[sel] capture unit_result/unit_cc slice sel into wb_data/wb_cc, go WB. unit_done of non-selected units is ignored in all states. unit_done during ISSUE is ignored.
- WB: wb_valid=1 one cycle; go IDLE. wb_data/wb_cc hold their values until the next capture.
- req_valid outside IDLE is ignored (not queued); controlpath must hold it until req_ready.
- Reset (reset_L=0 at a clock edge, any state incl. mid-WAIT): state IDLE, all outputs 0 except req_ready=1; wb_data, wb_cc, sel, counter, timeout_err cleared. In-flight unit is not signalled; units must reset together.

## Timing
- Request accepted at edge 0 -> unit_start high in cycle 1 -> earliest unit_done sampled in cycle 2 -> wb_valid in cycle 3 -> req_ready in cycle 4. Minimum turnaround 4 cycles; total = 3 + unit latency (cycles from start to done, >=1).
- All outputs registered or decoded from the state register only; no combinational path from req_valid/unit_done to any output.
- Back-to-back: req_valid held high yields a new ISSUE one cycle after returning to IDLE.

## Configuration
- DISPATCH_TIMEOUT_EN defined: 16-bit counter increments each WAIT cycle; if it reaches TIMEOUT_CYCLES-1 with no unit_done[sel], then next cycle: unit_abort[sel]=1, timeout_err set (sticky until reset), wb_data=0, wb_cc=4'b1000 (Z), go WB. unit_done coincident with the last counter cycle wins (normal capture, no abort).
- Not defined: no counter, unit_abort tied 0, timeout_err tied 0; WAIT is unbounded.

## Test plan
- Reset: drive reset_L=0 two cycles mid-WAIT -> next cycle req_ready=1, busy=0, wb_valid=0, unit_start=0, timeout_err=0.
- Unit 0, latency 1: req_unit=0, unit 0 returns 16'h0012 cc 4'b0000 one cycle after start -> unit_start=2'b01 cycle 1, wb_valid cycle 3 with wb_data=16'h0012, wb_cc=4'b0000, req_ready cycle 4.
- Unit 1, latency 17, unit 0 spuriously pulses done at cycle 5 -> ignored; wb_valid at cycle 19 with unit 1's result 16'hFFFE, cc 4'b0010.
- Illegal index (NUM_UNITS=3, req_unit=3) -> illegal_op pulse one cycle, unit_start stays 0, state remains IDLE.
- Watchdog (DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, unit never done) -> unit_abort[sel] and wb_valid with wb_data=0, wb_cc=4'b1000; timeout_err stays 1 until reset.
- Back-to-back: req_valid held, units 0 then 1, latency 2 each -> exactly two unit_start pulses, two wb_valid pulses 5 cycles apart.
